glyph_rain_sequencer: RTL and testbench

- Clock-domain animation controller for the glyph-mode rain display. Replaces a vsync-clocked frame register with a fully synchronous scheduler.
- Detects frame boundaries from the sync generator's vsync and advances the animation frame counter at a selectable rate. Sequences the intro "drop" phase, pause and single-step.
- Selects the palette id fed to the palette ROM, manually or by auto-cycling.

---
 rtl/glyph_rain_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_glyph_rain_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_rain_sequencer.sv
// ---------------------------------------------------------------------------
// glyph_rain_sequencer
//
// Frame scheduler for the glyph-mode rain display. It runs entirely in the
// pixel-clock domain. vsync and the step button are synchronised, and each
// rising edge of vsync counts as one frame boundary. On a boundary the block
// decides whether the animation frame counter advances. That decision depends
// on the speed divider, the pause/step controls and the intro drop sweep.
// The block also picks the palette id, either from pal_sel or by auto-cycling.
//
// Ports
//   clk        : pixel clock
//   reset      : asynchronous active-high reset
//   vsync      : vsync pulse from the sync generator (asynchronous)
//   pause      : level, freeze animation at the next boundary
//   step       : raw button, a rising edge requests one frame while paused
//   speed      : advance every 2^speed boundaries
//   auto_pal   : 1 = auto-cycle palettes, 0 = use pal_sel
//   pal_sel    : manual palette id
//   frame      : animation frame counter
//   frame_tick : one-cycle pulse in the first cycle a new frame value shows
//   drop_phase : high during the intro drop sweep
//   pal_id     : palette id for the palette ROM
//   state      : 0 INTRO, 1 RUN, 2 PAUSE_INTRO, 3 PAUSE_RUN
//
// Timing: all decisions happen in the cycle where vs_rise is high. The new
// frame value and frame_tick both appear one clock later.
// ---------------------------------------------------------------------------
module glyph_rain_sequencer #(
    parameter int FRAME_W  = 10,
    parameter int PAL_HOLD = 600
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               pause,
    input  logic               step,
    input  logic [1:0]         speed,
    input  logic               auto_pal,
    input  logic [1:0]         pal_sel,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               drop_phase,
    output logic [1:0]         pal_id,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        INTRO       = 2'd0,
        RUN         = 2'd1,
        PAUSE_INTRO = 2'd2,
        PAUSE_RUN   = 2'd3
    } state_e;

    localparam int PCW = (PAL_HOLD > 1) ? $clog2(PAL_HOLD) : 1;
    localparam logic [PCW-1:0] PAL_LAST = PCW'(PAL_HOLD - 1);

    // Synchronisers: two metastability flops and one edge-detect flop each.
    logic vs_s1_q, vs_s2_q, vs_s3_q;
    logic st_s1_q, st_s2_q, st_s3_q;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_q, tick_d;
    logic [2:0]         div_q, div_d;
    logic [PCW-1:0]     pcnt_q, pcnt_d;
    logic [1:0]         pal_q, pal_d;
    logic               pend_q, pend_d;

    logic       vs_rise;
    logic       st_rise;
    logic       div_eval;
    logic       adv;
    logic [2:0] div_lim;

    assign vs_rise = vs_s2_q & ~vs_s3_q;
    assign st_rise = st_s2_q & ~st_s3_q;

    // Terminal divider count for each speed: 2^speed - 1.
    always_comb begin
        div_lim = 3'd0;
        case (speed)
            2'd0: div_lim = 3'd0;
            2'd1: div_lim = 3'd1;
            2'd2: div_lim = 3'd3;
            2'd3: div_lim = 3'd7;
            default: div_lim = 3'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        frame_d  = frame_q;
        tick_d   = 1'b0;
        div_d    = div_q;
        pcnt_d   = pcnt_q;
        pal_d    = pal_q;
        pend_d   = pend_q;
        div_eval = 1'b0;
        adv      = 1'b0;

        if (vs_rise) begin
            case (state_q)
                INTRO: begin
                    // Entering pause takes priority over this boundary's advance.
                    if (pause) state_d = PAUSE_INTRO;
                    else       div_eval = 1'b1;
                end
                RUN: begin
                    if (pause) state_d = PAUSE_RUN;
                    else       div_eval = 1'b1;
                end
                PAUSE_INTRO, PAUSE_RUN: begin
                    if (!pause) begin
                        // Resume: the divider still runs on this same boundary.
                        state_d  = (state_q == PAUSE_INTRO) ? INTRO : RUN;
                        pend_d   = 1'b0;
                        div_eval = 1'b1;
                    end else if (pend_q) begin
                        // A step advances one frame and skips the divider.
                        adv    = 1'b1;
                        pend_d = 1'b0;
                    end
                end
                default: state_d = INTRO;
            endcase

            // The >= compare lets a speed decrease act at the next boundary.
            if (div_eval) begin
                if (div_q >= div_lim) begin
                    adv   = 1'b1;
                    div_d = 3'd0;
                end else begin
                    div_d = div_q + 3'd1;
                end
            end

            if (adv) begin
                frame_d = frame_q + 1'b1;
                tick_d  = 1'b1;
                // Wrapping out of the intro ends the drop sweep.
                if (&frame_q) begin
                    if (state_d == INTRO) begin
                        state_d = RUN;
                        drop_d  = 1'b0;
                    end else if (state_d == PAUSE_INTRO) begin
                        state_d = PAUSE_RUN;
                        drop_d  = 1'b0;
                    end
                end
            end

            // Palette only changes on a boundary, never in mid-frame.
            if (!auto_pal) begin
                pal_d  = pal_sel;
                pcnt_d = '0;
            end else if (adv) begin
                if (pcnt_q >= PAL_LAST) begin
                    pcnt_d = '0;
                    pal_d  = pal_q + 2'd1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end

        // A step edge is recorded only when the block is paused and stays
        // paused after this boundary. If it lands on the same cycle as a
        // consumed step, it re-arms for the following boundary.
        if (st_rise && state_q[1] && state_d[1]) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1_q <= 1'b0;
            vs_s2_q <= 1'b0;
            vs_s3_q <= 1'b0;
            st_s1_q <= 1'b0;
            st_s2_q <= 1'b0;
            st_s3_q <= 1'b0;
            state_q <= INTRO;
            drop_q  <= 1'b1;
            frame_q <= '0;
            tick_q  <= 1'b0;
            div_q   <= 3'd0;
            pcnt_q  <= '0;
            pal_q   <= 2'd0;
            pend_q  <= 1'b0;
        end else begin
            vs_s1_q <= vsync;
            vs_s2_q <= vs_s1_q;
            vs_s3_q <= vs_s2_q;
            st_s1_q <= step;
            st_s2_q <= st_s1_q;
            st_s3_q <= st_s2_q;
            state_q <= state_d;
            drop_q  <= drop_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            pcnt_q  <= pcnt_d;
            pal_q   <= pal_d;
            pend_q  <= pend_d;
        end
    end

    assign frame      = frame_q;
    assign frame_tick = tick_q;
    assign drop_phase = drop_q;
    assign pal_id     = pal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_glyph_rain_sequencer.sv
// Testbench for glyph_rain_sequencer.
//
// Each vsync pulse first steps a boundary-level model. When that model
// predicts an advance, the expected {frame, state, drop_phase, pal_id} is
// queued. A separate monitor pops one entry for every frame_tick and compares
// it with the outputs. Directed checks with hand-computed constants cover the
// key points.
module tb_glyph_rain_sequencer;

  localparam int FW = 10;
  localparam int PH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          pause;
  logic          step;
  logic [1:0]    speed;
  logic          auto_pal;
  logic [1:0]    pal_sel;
  logic [FW-1:0] frame;
  logic          frame_tick;
  logic          drop_phase;
  logic [1:0]    pal_id;
  logic [1:0]    state;

  glyph_rain_sequencer #(.FRAME_W(FW), .PAL_HOLD(PH)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause), .step(step),
    .speed(speed), .auto_pal(auto_pal), .pal_sel(pal_sel), .frame(frame),
    .frame_tick(frame_tick), .drop_phase(drop_phase), .pal_id(pal_id),
    .state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int tests = 0;
  int failed = 0;
  int tick_cnt = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && frame_tick) begin
      tick_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        check("tick_outputs", {17'd0, frame, state, drop_phase, pal_id},
              {17'd0, exp_q.pop_front()});
      end
    end
  end

  // boundary-level reference model
  logic [FW-1:0] m_frame;
  logic [1:0]    m_state;
  logic          m_drop;
  logic [1:0]    m_pal;
  int            m_div;
  int            m_pcnt;
  bit            m_pend;

  task automatic model_reset();
    m_frame = '0; m_state = 2'd0; m_drop = 1'b1; m_pal = 2'd0;
    m_div = 0; m_pcnt = 0; m_pend = 0;
    exp_q.delete();
  endtask

  task automatic model_boundary(output bit adv);
    bit run_div;
    adv = 0;
    run_div = 0;
    if (m_state >= 2) begin
      if (!pause) begin
        m_state = m_state - 2'd2;
        m_pend = 0;
        run_div = 1;
      end else if (m_pend) begin
        adv = 1;
        m_pend = 0;
      end
    end else if (pause) begin
      m_state = m_state + 2'd2;
    end else begin
      run_div = 1;
    end
    if (run_div) begin
      if (m_div >= (1 << speed) - 1) begin adv = 1; m_div = 0; end
      else m_div++;
    end
    if (adv) begin
      if (m_frame == {FW{1'b1}} && (m_state == 2'd0 || m_state == 2'd2)) begin
        m_state = m_state + 2'd1;
        m_drop = 1'b0;
      end
      m_frame = m_frame + 1'b1;
    end
    if (!auto_pal) begin
      m_pal = pal_sel;
      m_pcnt = 0;
    end else if (adv) begin
      if (m_pcnt == PH - 1) begin m_pcnt = 0; m_pal = m_pal + 2'd1; end
      else m_pcnt++;
    end
  endtask

  // driver tasks
  task automatic vs_pulse();
    bit adv;
    model_boundary(adv);
    if (adv) exp_q.push_back({m_frame, m_state, m_drop, m_pal});
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tick_timing", {31'd0, frame_tick}, {31'd0, adv});
    vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) vs_pulse();
  endtask

  task automatic step_pulse();
    if (m_state >= 2) m_pend = 1;
    @(negedge clk);
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // stimulus
  initial begin
    int t0;
    reset = 1'b1; vsync = 1'b0; pause = 1'b0; step = 1'b0;
    speed = 2'd0; auto_pal = 1'b0; pal_sel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_frame", {22'd0, frame}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_drop", {31'd0, drop_phase}, 32'd1);
    check("rst_pal", {30'd0, pal_id}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // speed 0: five frames, five ticks
    t0 = tick_cnt;
    vs_pulses(5);
    check("sp0_frame", {22'd0, frame}, 32'd5);
    check("sp0_ticks", tick_cnt - t0, 32'd5);
    check("sp0_drop", {31'd0, drop_phase}, 32'd1);
    check("sp0_state", {30'd0, state}, 32'd0);

    // speed 2: advances on boundaries 4 and 8, then a speed drop acts at once
    do_reset();
    speed = 2'd2;
    vs_pulses(3);
    check("sp2_b3", {22'd0, frame}, 32'd0);
    vs_pulse();
    check("sp2_b4", {22'd0, frame}, 32'd1);
    vs_pulses(4);
    check("sp2_b8", {22'd0, frame}, 32'd2);
    vs_pulses(2);
    check("sp2_b10", {22'd0, frame}, 32'd2);
    speed = 2'd0;
    vs_pulse();
    check("sp_drop_next", {22'd0, frame}, 32'd3);

    // full intro sweep and wrap into RUN
    do_reset();
    vs_pulses(1023);
    check("pre_wrap_frame", {22'd0, frame}, 32'd1023);
    check("pre_wrap_state", {30'd0, state}, 32'd0);
    vs_pulse();
    check("wrap_frame", {22'd0, frame}, 32'd0);
    check("wrap_state", {30'd0, state}, 32'd1);
    check("wrap_drop", {31'd0, drop_phase}, 32'd0);
    vs_pulses(100);
    check("run_frame100", {22'd0, frame}, 32'd100);

    // pause, collapsed steps, resume
    pause = 1'b1;
    vs_pulse();
    check("pause_state", {30'd0, state}, 32'd3);
    vs_pulses(10);
    check("pause_hold", {22'd0, frame}, 32'd100);
    step_pulse(); step_pulse(); step_pulse();
    vs_pulse();
    check("step_once", {22'd0, frame}, 32'd101);
    vs_pulse();
    check("step_cleared", {22'd0, frame}, 32'd101);
    pause = 1'b0;
    vs_pulse();
    check("resume_state", {30'd0, state}, 32'd1);
    check("resume_frame", {22'd0, frame}, 32'd102);

    // reset in mid-frame while in PAUSE_RUN at frame 37
    do_reset();
    pal_sel = 2'd3;
    vs_pulses(1024 + 37);
    pause = 1'b1;
    vs_pulse();
    check("pre_rst_frame", {22'd0, frame}, 32'd37);
    check("pre_rst_state", {30'd0, state}, 32'd3);
    check("pre_rst_pal", {30'd0, pal_id}, 32'd3);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_frame", {22'd0, frame}, 32'd0);
    check("mid_rst_state", {30'd0, state}, 32'd0);
    check("mid_rst_drop", {31'd0, drop_phase}, 32'd1);
    check("mid_rst_pal", {30'd0, pal_id}, 32'd0);
    vsync = 1'b0; pause = 1'b0; pal_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_tick", {31'd0, frame_tick}, 32'd0);
    end
    t0 = tick_cnt;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_ticks", tick_cnt - t0, 32'd0);
    check("post_rst_frame", {22'd0, frame}, 32'd0);

    // auto palette, PAL_HOLD = 4
    auto_pal = 1'b1;
    vs_pulses(4);
    check("apal_4", {30'd0, pal_id}, 32'd1);
    vs_pulses(4);
    check("apal_8", {30'd0, pal_id}, 32'd2);
    vs_pulses(4);
    check("apal_12", {30'd0, pal_id}, 32'd3);
    vs_pulses(3);
    check("apal_15", {30'd0, pal_id}, 32'd3);
    vs_pulse();
    check("apal_16", {30'd0, pal_id}, 32'd0);
    auto_pal = 1'b0; pal_sel = 2'd2;
    repeat (5) @(negedge clk);
    check("mpal_midframe", {30'd0, pal_id}, 32'd0);
    vs_pulse();
    check("mpal_boundary", {30'd0, pal_id}, 32'd2);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
